usb_rx: RTL and testbench
=========================

Name: usb_rx

Overview:
- USB full-speed receive path; the counterpart of the tx block on the same bus.
- Oversamples D+/D− at 8 clocks per bit, recovers bit timing and NRZI-decodes the line.
- Strips stuffed bits, checks SYNC and PID, and captures token fields.
- Writes data-packet payload into the shared packet buffer, holding back the 2 CRC16 bytes, and reports packet type, completion and errors to the protocol controller.

Parameters:
CLKS_PER_BIT, 8, clocks per USB bit time; the sample point is count 3 after the last line edge.
MAX_BYTES, 64, maximum data payload bytes per packet.

Ports:
clk  input  1  system clock, 8x bit rate.
n_rst  input  1  asynchronous active-low reset.
dplus_in  input  1  raw D+ line, asynchronous.
dminus_in  input  1  raw D− line, asynchronous.
buffer_occupancy  input  7  bytes currently held in the shared buffer.
rx_packet  output  3  decoded PID: 0 none, 1 ACK, 2 NAK, 3 STALL, 4 DATA0, 5 DATA1, 6 IN, 7 OUT (same encoding as tx_packet).
rx_data_ready  output  1  1-cycle pulse on valid EOP of an error-free packet.
rx_transfer_active  output  1  high from SYNC detection through end of EOP or error.
rx_error  output  1  sticky error flag.
flush  output  1  1-cycle pulse when a DATA0/DATA1 PID is accepted.
store_rx_packet_data  output  1  1-cycle write strobe to the buffer.
rx_packet_data  output  8  byte written with store_rx_packet_data.
rx_address  output  7  token address field.
rx_endpoint  output  4  token endpoint field.

Behaviour:
- Reset (async, n_rst=0):
  - all outputs 0.
  - internal previous-line value = J (D+=1).
  - state IDLE; counters 0.
  - Reset mid-packet aborts immediately; no further strobes.
- Input synchronisation and timing:
  - 2-flop synchroniser on each line, so input latency is 2 clocks.
  - Bit timer reset to 0 on any change of synchronised D+.
  - Otherwise the timer counts mod CLKS_PER_BIT; the sample strobe fires at count 3.
- NRZI decode:
  - Decoded bit = 1 if the sampled D+ equals the previous sample, 0 if it differs.
  - SE0 (D+=0, D−=0) is flagged separately and never decoded as a bit.
- Bit unstuffing:
  - Track consecutive 1s (saturating); reset the count on any 0.
  - After six 1s the next bit is discarded when it is 0.
  - If that bit is 1 → stuff error.
- Byte assembly:
  - LSB first; 3-bit bit counter.
  - byte_done pulses when the 8th unstuffed bit is taken.
- States:
  - IDLE: wait for the first K sample → SYNC; set rx_transfer_active.
  - SYNC:
    - Expect 0x80 (bits 0000000 then 1).
    - Match → PID.
    - Any mismatch → ERR.
  - PID:
    - Require byte[7:4] == ~byte[3:0].
    - Map PIDs: 0xD2→1, 0x5A→2, 0x1E→3, 0xC3→4, 0x4B→5, 0x69→6, 0xE1→7.
    - rx_packet updates the cycle after byte_done.
    - DATA PIDs additionally pulse flush that cycle.
    - Next state: DATA for DATA0/DATA1, TOKEN for IN/OUT, EOPWAIT for handshakes.
    - Failed check or any other PID → ERR.
  - TOKEN:
    - Receive 16 bits. Bits 0–6 → rx_address, bits 7–10 → rx_endpoint; CRC5 is discarded, not checked.
    - Both fields update after bit 10.
    - → EOPWAIT after bit 16.
  - DATA:
    - 2-deep holdback register.
    - On byte_done with 2 bytes already held: the oldest byte drives rx_packet_data and store_rx_packet_data pulses 1 cycle later.
    - Bytes are stored in arrival order.
    - A byte that would be stored while buffer_occupancy ≥ MAX_BYTES → ERR.
    - SE0 at a byte boundary → EOP; the 2 held bytes (CRC16) are dropped.
    - SE0 mid-byte → ERR.
    - A packet with fewer than 2 bytes after PID → ERR.
  - EOPWAIT: the next sample must be SE0, else ERR.
  - EOP:
    - Require 2 consecutive SE0 samples, then a J sample.
    - Then pulse rx_data_ready, clear rx_transfer_active and return to IDLE.
    - Any K sample or a third SE0 sample → ERR.
  - ERR:
    - rx_error=1 and rx_transfer_active=0.
    - Wait for a full SE0→J sequence, then → IDLE.
- rx_error clears when the next SYNC is entered; rx_packet holds until the next accepted PID.
- No stores or ready pulse are issued after an error.

Test Plan:
- ACK: SYNC, PID 0xD2, EOP → rx_packet=1; rx_data_ready pulses once; no store; rx_error=0.
- DATA0 with payload 0x11,0x22,0x33 and CRC bytes 0xAB,0xCD, occupancy 0 → flush pulse; exactly 3 stores (0x11,0x22,0x33); rx_packet=4; ready pulse.
- Bit stuffing:
  - DATA1 payload 0xFF,0x7E,CRC with correct stuff bits → stores 0xFF,0x7E.
  - Same packet with the stuff bit forced to 1 → rx_error=1, no ready pulse.
- IN token with address 0x05, endpoint 0x3 → rx_packet=6, rx_address=5, rx_endpoint=3, ready pulse; then ACK with no idle gap → rx_packet=1.
- Errors:
  - PID 0xD3 → rx_error=1, rx_packet unchanged.
  - Next valid ACK clears rx_error.
  - DATA0 with occupancy held at 64 → rx_error on the first store attempt.
- Reset: assert n_rst mid-DATA payload → all outputs 0 immediately; the next full ACK decodes correctly.

Source files
------------

// File: rtl/usb_rx.sv
// USB full-speed receive path: 8x oversampled line recovery, NRZI decode, bit
// unstuffing and packet parsing, with payload written to the shared buffer.
module usb_rx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_BYTES    = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       dplus_in,
    input  logic       dminus_in,
    input  logic [6:0] buffer_occupancy,
    output logic [2:0] rx_packet,
    output logic       rx_data_ready,
    output logic       rx_transfer_active,
    output logic       rx_error,
    output logic       flush,
    output logic       store_rx_packet_data,
    output logic [7:0] rx_packet_data,
    output logic [6:0] rx_address,
    output logic [3:0] rx_endpoint
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] SAMPLE_PT  = TW'(3);
    localparam logic [6:0]    OCC_LIMIT  = 7'(MAX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_PID, S_TOKEN, S_DATA, S_EOPWAIT, S_EOP, S_ERR
    } state_t;

    state_t      state, next_state;
    logic [1:0]  dp_sync, dm_sync;
    logic        dp, dm, dp_last;
    logic [TW-1:0] timer;
    logic        sample, se0, j_line, k_line;
    logic        prev_line, line_bit;
    logic [2:0]  bit_cnt, ones;
    logic [7:0]  shreg, byte_val;
    logic        dec_en, bit_valid, take, stuff_drop, stuff_err, byte_done;
    logic [10:0] tok_sh, tok_val;
    logic [3:0]  tok_cnt;
    logic [7:0]  hold0, hold1;
    logic [1:0]  held;
    logic        se0_two, err_se0;
    logic [2:0]  pid_code;
    logic        pid_ok;

    // Line synchroniser and bit timer; any D+ transition re-centres the sample point.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_sync <= 2'b11;
            dm_sync <= 2'b00;
            dp_last <= 1'b1;
            timer   <= '0;
        end else begin
            dp_sync <= {dp_sync[0], dplus_in};
            dm_sync <= {dm_sync[0], dminus_in};
            dp_last <= dp_sync[1];
            if (dp_sync[1] != dp_last || timer == TIMER_LAST) timer <= '0;
            else timer <= timer + TW'(1);
        end
    end

    assign dp       = dp_sync[1];
    assign dm       = dm_sync[1];
    assign sample   = (timer == SAMPLE_PT);
    assign se0      = !dp && !dm;
    assign j_line   = dp && !dm;
    assign k_line   = !dp && dm;
    assign line_bit = (dp == prev_line);

    assign dec_en     = (state inside {S_SYNC, S_PID, S_TOKEN, S_DATA, S_EOPWAIT}) ||
                        (state == S_IDLE && k_line);
    assign bit_valid  = sample && !se0 && dec_en;
    assign stuff_drop = bit_valid && (ones == 3'd6) && !line_bit;
    assign stuff_err  = bit_valid && (ones == 3'd6) && line_bit;
    assign take       = bit_valid && (ones != 3'd6);
    assign byte_done  = take && (bit_cnt == 3'd7);
    assign byte_val   = {line_bit, shreg[7:1]};
    assign tok_val    = {line_bit, tok_sh[10:1]};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_line <= 1'b1;
            bit_cnt   <= '0;
            ones      <= '0;
            shreg     <= '0;
        end else begin
            if (sample && !se0) prev_line <= dp;
            if (!dec_en) begin
                bit_cnt <= '0;
                ones    <= '0;
            end else if (take) begin
                shreg   <= byte_val;
                bit_cnt <= bit_cnt + 3'd1;
                ones    <= line_bit ? ones + 3'd1 : 3'd0;
            end else if (stuff_drop) begin
                ones <= '0;
            end
        end
    end

    always_comb begin
        pid_code = 3'd0;
        case (byte_val)
            8'hD2:   pid_code = 3'd1;
            8'h5A:   pid_code = 3'd2;
            8'h1E:   pid_code = 3'd3;
            8'hC3:   pid_code = 3'd4;
            8'h4B:   pid_code = 3'd5;
            8'h69:   pid_code = 3'd6;
            8'hE1:   pid_code = 3'd7;
            default: pid_code = 3'd0;
        endcase
        pid_ok = (byte_val[7:4] == ~byte_val[3:0]) && (pid_code != 3'd0);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (sample && k_line) next_state = S_SYNC;
            S_SYNC: begin
                if (stuff_err || (sample && se0)) next_state = S_ERR;
                else if (byte_done) next_state = (byte_val == 8'h80) ? S_PID : S_ERR;
            end
            S_PID: begin
                if (stuff_err || (sample && se0)) next_state = S_ERR;
                else if (byte_done) begin
                    if (!pid_ok)                 next_state = S_ERR;
                    else if (pid_code >= 3'd6)   next_state = S_TOKEN;
                    else if (pid_code >= 3'd4)   next_state = S_DATA;
                    else                         next_state = S_EOPWAIT;
                end
            end
            S_TOKEN: begin
                if (stuff_err || (sample && se0)) next_state = S_ERR;
                else if (take && tok_cnt == 4'd15) next_state = S_EOPWAIT;
            end
            S_DATA: begin
                if (stuff_err) next_state = S_ERR;
                else if (sample && se0)
                    next_state = (bit_cnt == 3'd0 && held == 2'd2) ? S_EOP : S_ERR;
                else if (byte_done && held == 2'd2 && buffer_occupancy >= OCC_LIMIT)
                    next_state = S_ERR;
            end
            // A trailing stuffed 0 may still arrive here and is silently dropped.
            S_EOPWAIT: begin
                if (sample && se0) next_state = S_EOP;
                else if (take || stuff_err) next_state = S_ERR;
            end
            S_EOP: begin
                if (sample) begin
                    if (se0)                   next_state = se0_two ? S_ERR : S_EOP;
                    else if (j_line && se0_two) next_state = S_IDLE;
                    else                       next_state = S_ERR;
                end
            end
            S_ERR: if (sample && j_line && err_se0) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_packet            <= '0;
            rx_data_ready        <= 1'b0;
            rx_transfer_active   <= 1'b0;
            rx_error             <= 1'b0;
            flush                <= 1'b0;
            store_rx_packet_data <= 1'b0;
            rx_packet_data       <= '0;
            rx_address           <= '0;
            rx_endpoint          <= '0;
            hold0                <= '0;
            hold1                <= '0;
            held                 <= '0;
            tok_sh               <= '0;
            tok_cnt              <= '0;
            se0_two              <= 1'b0;
            err_se0              <= 1'b0;
        end else begin
            rx_data_ready        <= 1'b0;
            flush                <= 1'b0;
            store_rx_packet_data <= 1'b0;
            if (next_state == S_ERR && state != S_ERR) begin
                rx_error           <= 1'b1;
                rx_transfer_active <= 1'b0;
                err_se0            <= sample && se0;
            end else if (state == S_ERR && sample && se0) begin
                err_se0 <= 1'b1;
            end
            if (next_state == S_EOP && state != S_EOP) se0_two <= 1'b0;
            case (state)
                S_IDLE: if (next_state == S_SYNC) begin
                    rx_transfer_active <= 1'b1;
                    rx_error           <= 1'b0;
                end
                S_PID: if (byte_done && next_state != S_ERR) begin
                    rx_packet <= pid_code;
                    flush     <= (next_state == S_DATA);
                    held      <= '0;
                    tok_cnt   <= '0;
                end
                S_TOKEN: if (take) begin
                    tok_sh  <= tok_val;
                    tok_cnt <= tok_cnt + 4'd1;
                    if (tok_cnt == 4'd10) begin
                        rx_address  <= tok_val[6:0];
                        rx_endpoint <= tok_val[10:7];
                    end
                end
                // The two most recent bytes stay held back: they are the CRC16 at EOP.
                S_DATA: if (byte_done && next_state == S_DATA) begin
                    if (held == 2'd2) begin
                        rx_packet_data       <= hold0;
                        store_rx_packet_data <= 1'b1;
                        hold0                <= hold1;
                        hold1                <= byte_val;
                    end else if (held == 2'd0) begin
                        hold0 <= byte_val;
                        held  <= 2'd1;
                    end else begin
                        hold1 <= byte_val;
                        held  <= 2'd2;
                    end
                end
                S_EOP: begin
                    if (sample && se0) se0_two <= 1'b1;
                    if (next_state == S_IDLE) begin
                        rx_data_ready      <= 1'b1;
                        rx_transfer_active <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_rx.sv
// Self-checking bench for usb_rx: packets are built as byte lists, stuffed and
// NRZI-encoded onto the line; a monitor checks stores and ready pulses against queues.
module tb_usb_rx;
    logic       clk = 1'b0;
    logic       n_rst;
    logic       dplus_in, dminus_in;
    logic [6:0] buffer_occupancy;
    logic [2:0] rx_packet;
    logic       rx_data_ready, rx_transfer_active, rx_error, flush, store_rx_packet_data;
    logic [7:0] rx_packet_data;
    logic [6:0] rx_address;
    logic [3:0] rx_endpoint;

    always #5 clk = ~clk;

    usb_rx dut (
        .clk(clk), .n_rst(n_rst), .dplus_in(dplus_in), .dminus_in(dminus_in),
        .buffer_occupancy(buffer_occupancy), .rx_packet(rx_packet),
        .rx_data_ready(rx_data_ready), .rx_transfer_active(rx_transfer_active),
        .rx_error(rx_error), .flush(flush), .store_rx_packet_data(store_rx_packet_data),
        .rx_packet_data(rx_packet_data), .rx_address(rx_address), .rx_endpoint(rx_endpoint)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  exp_q[$];
    logic [13:0] rdy_q[$];
    logic [7:0]  tx_bytes[$];
    logic [7:0]  pay_q[$];
    logic [7:0]  crc_q[$];
    logic [2:0]  m_pkt;
    logic [6:0]  m_addr;
    logic [3:0]  m_ep;
    logic        m_err;
    int          m_flush = 0;
    int          flush_seen = 0;
    logic [7:0]  mon_b;
    logic [13:0] mon_r;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (flush) flush_seen++;
            if (store_rx_packet_data) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL store: got byte %02h, expected no store", rx_packet_data);
                end else begin
                    mon_b = exp_q.pop_front();
                    check("store byte", {24'd0, rx_packet_data}, {24'd0, mon_b});
                end
            end
            if (rx_data_ready) begin
                if (rdy_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL ready: got pulse with rx_packet=%0d, expected none", rx_packet);
                end else begin
                    mon_r = rdy_q.pop_front();
                    check("ready pkt/addr/ep", {18'd0, rx_packet, rx_address, rx_endpoint},
                          {18'd0, mon_r});
                end
            end
        end
    end

    function automatic logic [7:0] pid_byte(input logic [2:0] c);
        case (c)
            3'd1: return 8'hD2;
            3'd2: return 8'h5A;
            3'd3: return 8'h1E;
            3'd4: return 8'hC3;
            3'd5: return 8'h4B;
            3'd6: return 8'h69;
            3'd7: return 8'hE1;
            default: return 8'h00;
        endcase
    endfunction

    task automatic drive(input logic dp, input logic dm);
        dplus_in  = dp;
        dminus_in = dm;
        repeat (8) @(negedge clk);
    endtask

    // SYNC + tx_bytes, LSB first, stuffed after six 1s, NRZI from J, then SE0 SE0 J.
    task automatic send_packet(input bit bad_stuff, input int abort_bits, input int gap);
        bit         bits[$];
        int         ones;
        bit         lvl;
        bit         bad_done;
        logic [7:0] b;
        ones = 0; bad_done = 0; lvl = 1;
        for (int i = 0; i <= tx_bytes.size(); i++) begin
            b = (i == 0) ? 8'h80 : tx_bytes[i-1];
            for (int k = 0; k < 8; k++) begin
                bits.push_back(b[k]);
                ones = b[k] ? ones + 1 : 0;
                if (ones == 6) begin
                    bits.push_back(bad_stuff && !bad_done);
                    if (bad_stuff) bad_done = 1;
                    ones = 0;
                end
            end
        end
        for (int i = 0; i < bits.size(); i++) begin
            if (abort_bits >= 0 && i == abort_bits) return;
            if (!bits[i]) lvl = !lvl;
            drive(lvl, !lvl);
        end
        drive(0, 0);
        drive(0, 0);
        drive(1, 0);
        repeat (gap) drive(1, 0);
    endtask

    task automatic do_handshake(input logic [2:0] code, input int gap);
        tx_bytes = {};
        tx_bytes.push_back(pid_byte(code));
        rdy_q.push_back({code, m_addr, m_ep});
        m_pkt = code; m_err = 0;
        send_packet(0, -1, gap);
    endtask

    task automatic do_token(input logic [2:0] code, input logic [6:0] a, input logic [3:0] e,
                            input int gap);
        logic [15:0] tok;
        tok = {5'($urandom), e, a};
        tx_bytes = {};
        tx_bytes.push_back(pid_byte(code));
        tx_bytes.push_back(tok[7:0]);
        tx_bytes.push_back(tok[15:8]);
        m_addr = a; m_ep = e; m_pkt = code; m_err = 0;
        rdy_q.push_back({code, a, e});
        send_packet(0, -1, gap);
    endtask

    task automatic do_data(input logic [2:0] code, input logic [6:0] occ, input bit bad_stuff,
                           input int abort_bits, input int gap);
        bit fail;
        buffer_occupancy = occ;
        tx_bytes = {};
        tx_bytes.push_back(pid_byte(code));
        foreach (pay_q[i]) tx_bytes.push_back(pay_q[i]);
        foreach (crc_q[i]) tx_bytes.push_back(crc_q[i]);
        m_pkt = code; m_err = 0; m_flush++;
        fail = bad_stuff || (pay_q.size() + crc_q.size() < 2) ||
               (occ >= 7'd64 && pay_q.size() > 0);
        if (abort_bits < 0) begin
            if (fail) m_err = 1;
            else begin
                foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
                rdy_q.push_back({code, m_addr, m_ep});
            end
        end
        send_packet(bad_stuff, abort_bits, gap);
    endtask

    task automatic do_badpid(input logic [7:0] b, input int gap);
        tx_bytes = {};
        tx_bytes.push_back(b);
        m_err = 1;
        send_packet(0, -1, gap);
    endtask

    task automatic check_state(input string tag);
        check({tag, " rx_error"}, {31'd0, rx_error}, {31'd0, m_err});
        check({tag, " rx_packet"}, {29'd0, rx_packet}, {29'd0, m_pkt});
        check({tag, " rx_address"}, {25'd0, rx_address}, {25'd0, m_addr});
        check({tag, " rx_endpoint"}, {28'd0, rx_endpoint}, {28'd0, m_ep});
        check({tag, " transfer_active"}, {31'd0, rx_transfer_active}, 32'd0);
        check({tag, " stores pending"}, exp_q.size(), 32'd0);
        check({tag, " ready pending"}, rdy_q.size(), 32'd0);
        check({tag, " flush count"}, flush_seen, m_flush);
        exp_q = {};
        rdy_q = {};
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rx_packet"}, {29'd0, rx_packet}, 32'd0);
        check({tag, " rx_data_ready"}, {31'd0, rx_data_ready}, 32'd0);
        check({tag, " transfer_active"}, {31'd0, rx_transfer_active}, 32'd0);
        check({tag, " rx_error"}, {31'd0, rx_error}, 32'd0);
        check({tag, " flush"}, {31'd0, flush}, 32'd0);
        check({tag, " store"}, {31'd0, store_rx_packet_data}, 32'd0);
        check({tag, " rx_packet_data"}, {24'd0, rx_packet_data}, 32'd0);
        check({tag, " rx_address"}, {25'd0, rx_address}, 32'd0);
        check({tag, " rx_endpoint"}, {28'd0, rx_endpoint}, 32'd0);
    endtask

    function automatic void fill_crc();
        crc_q = {};
        crc_q.push_back(8'($urandom));
        crc_q.push_back(8'($urandom));
    endfunction

    initial begin
        int         kind, len, gap;
        logic [3:0] lo, flip;
        n_rst = 0; dplus_in = 1; dminus_in = 0; buffer_occupancy = '0;
        m_pkt = 0; m_addr = 0; m_ep = 0; m_err = 0;
        repeat (4) @(negedge clk);
        check_all_zero("reset");
        n_rst = 1;
        repeat (32) @(negedge clk);

        do_handshake(3'd1, 2);
        check_state("ack");

        pay_q = {8'h11, 8'h22, 8'h33}; crc_q = {8'hAB, 8'hCD};
        do_data(3'd4, 7'd0, 0, -1, 2);
        check_state("data0");

        pay_q = {8'hFF, 8'h7E}; fill_crc();
        do_data(3'd5, 7'd10, 0, -1, 2);
        check_state("data1 stuffed");
        do_data(3'd5, 7'd10, 1, -1, 2);
        check_state("stuff error");

        do_token(3'd6, 7'h05, 4'h3, 0);
        do_handshake(3'd1, 2);
        check_state("in then ack");

        do_badpid(8'hD3, 2);
        check_state("bad pid");
        do_handshake(3'd1, 2);
        check_state("ack clears error");

        pay_q = {8'h11, 8'h22, 8'h33}; fill_crc();
        do_data(3'd4, 7'd64, 0, -1, 2);
        check_state("occupancy full");
        buffer_occupancy = '0;

        pay_q = {}; crc_q = {8'h5C};
        do_data(3'd4, 7'd0, 0, -1, 2);
        check_state("short data");

        pay_q = {8'h11, 8'h22, 8'h33}; fill_crc();
        do_data(3'd4, 7'd0, 0, 30, 0);
        check("mid-packet transfer_active", {31'd0, rx_transfer_active}, 32'd1);
        n_rst = 0;
        #1;
        check_all_zero("async reset");
        m_pkt = 0; m_addr = 0; m_ep = 0; m_err = 0;
        dplus_in = 1; dminus_in = 0;
        repeat (16) @(negedge clk);
        n_rst = 1;
        repeat (32) @(negedge clk);
        do_handshake(3'd1, 2);
        check_state("ack after reset");

        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 9);
            gap  = $urandom_range(1, 4);
            if (kind <= 2) begin
                do_handshake(3'($urandom_range(1, 3)), gap);
            end else if (kind <= 4) begin
                do_token(3'($urandom_range(6, 7)), 7'($urandom), 4'($urandom), gap);
            end else if (kind <= 8) begin
                len = $urandom_range(0, 6);
                pay_q = {};
                for (int k = 0; k < len; k++)
                    pay_q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
                fill_crc();
                do_data(3'($urandom_range(4, 5)), 7'($urandom_range(0, 63)), 0, -1, gap);
            end else begin
                lo   = 4'($urandom);
                flip = 4'($urandom_range(1, 15));
                do_badpid({~lo ^ flip, lo}, gap);
            end
            check_state("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
